// File: rtl/dma_dispatch_pkg.sv
// Shared types and datamover command field layout for the DMA command dispatcher.
// No logic, no latency; pure definitions.
package dma_dispatch_pkg;

    localparam int DMA_CMD_W = 104;
    localparam int DMA_STS_W = 32;

    typedef logic engine_id_t;

    localparam int CMD_BTT_LSB   = 0;
    localparam int CMD_BTT_MSB   = 22;
    localparam int CMD_SADDR_LSB = 32;
    localparam int CMD_SADDR_MSB = 95;
    localparam int CMD_TAG_LSB   = 96;
    localparam int CMD_TAG_MSB   = 99;

    function automatic logic [3:0] cmd_tag(input logic [DMA_CMD_W-1:0] cmd);
        return cmd[CMD_TAG_MSB:CMD_TAG_LSB];
    endfunction

endpackage

// File: rtl/dma_order_fifo.sv
// Order FIFO of engine ids, one entry per outstanding command; head visible combinationally.
// Push/pop take effect at the clock edge; caller must not push when full or pop when empty.
module dma_order_fifo
    import dma_dispatch_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  engine_id_t push_id,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output engine_id_t head
);

    localparam int AW = $clog2(DEPTH);

    engine_id_t  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_id;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/dma_cmd_dispatcher.sv
// Routes commands to two datamover engines by tdest[0] and merges their status in issue order; 1-cycle latency both paths.
// Backpressure: cmd stalls on busy target register or MAX_OUTSTANDING; only the expected engine's status is accepted.
module dma_cmd_dispatcher
    import dma_dispatch_pkg::*;
#(
    parameter int CMD_W           = DMA_CMD_W,
    parameter int STS_W           = DMA_STS_W,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = 5
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [CMD_W-1:0]   s_axis_cmd_tdata,
    input  logic [7:0]         s_axis_cmd_tdest,
    input  logic               s_axis_cmd_tvalid,
    output logic               s_axis_cmd_tready,
    output logic [CMD_W-1:0]   m_axis_cmd0_tdata,
    output logic               m_axis_cmd0_tvalid,
    input  logic               m_axis_cmd0_tready,
    output logic [CMD_W-1:0]   m_axis_cmd1_tdata,
    output logic               m_axis_cmd1_tvalid,
    input  logic               m_axis_cmd1_tready,
    input  logic [STS_W-1:0]   s_axis_sts0_tdata,
    input  logic               s_axis_sts0_tvalid,
    output logic               s_axis_sts0_tready,
    input  logic [STS_W-1:0]   s_axis_sts1_tdata,
    input  logic               s_axis_sts1_tvalid,
    output logic               s_axis_sts1_tready,
    output logic [STS_W-1:0]   m_axis_sts_tdata,
    output logic               m_axis_sts_tvalid,
    input  logic               m_axis_sts_tready,
    output logic               m_axis_sts_tlast,
    output logic [STS_W/8-1:0] m_axis_sts_tkeep,
    output logic [CNT_W-1:0]   outstanding,
    output logic               idle
);

    engine_id_t       sel;
    engine_id_t       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             eng_free;
    logic             cmd_acc;
    logic             sts_slot;
    logic             sts_acc;
    logic             cmd0_v, cmd1_v, sts_v;
    logic [CMD_W-1:0] cmd0_d, cmd1_d;
    logic [STS_W-1:0] sts_d;
    logic [CNT_W-1:0] cnt;
    logic             unused_tdest;

    assign unused_tdest = ^s_axis_cmd_tdest[7:1];
    assign sel          = s_axis_cmd_tdest[0];

    // Ready depends only on tdest and internal state, never on tvalid.
    assign eng_free          = sel ? (!cmd1_v || m_axis_cmd1_tready) : (!cmd0_v || m_axis_cmd0_tready);
    assign s_axis_cmd_tready = ap_rst_n && !fifo_full && eng_free;
    assign cmd_acc           = s_axis_cmd_tvalid && s_axis_cmd_tready;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            cmd0_v <= 1'b0;
            cmd0_d <= '0;
            cmd1_v <= 1'b0;
            cmd1_d <= '0;
        end else begin
            if (cmd_acc && !sel) begin
                cmd0_v <= 1'b1;
                cmd0_d <= s_axis_cmd_tdata;
            end else if (m_axis_cmd0_tready) begin
                cmd0_v <= 1'b0;
            end
            if (cmd_acc && sel) begin
                cmd1_v <= 1'b1;
                cmd1_d <= s_axis_cmd_tdata;
            end else if (m_axis_cmd1_tready) begin
                cmd1_v <= 1'b0;
            end
        end
    end

    dma_order_fifo #(.DEPTH(MAX_OUTSTANDING)) u_order_fifo (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .push    (cmd_acc),
        .push_id (sel),
        .pop     (sts_acc),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head)
    );

    // An empty FIFO keeps both status readies low, so a same-cycle push cannot be popped.
    assign sts_slot           = ap_rst_n && !fifo_empty && (!sts_v || m_axis_sts_tready);
    assign s_axis_sts0_tready = sts_slot && (head == 1'b0);
    assign s_axis_sts1_tready = sts_slot && (head == 1'b1);
    assign sts_acc            = (s_axis_sts0_tvalid && s_axis_sts0_tready) ||
                                (s_axis_sts1_tvalid && s_axis_sts1_tready);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            sts_v <= 1'b0;
            sts_d <= '0;
        end else if (sts_acc) begin
            sts_v <= 1'b1;
            sts_d <= head ? s_axis_sts1_tdata : s_axis_sts0_tdata;
        end else if (m_axis_sts_tready) begin
            sts_v <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            cnt <= '0;
        end else begin
            case ({cmd_acc, sts_acc})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign m_axis_cmd0_tdata  = cmd0_d;
    assign m_axis_cmd0_tvalid = cmd0_v;
    assign m_axis_cmd1_tdata  = cmd1_d;
    assign m_axis_cmd1_tvalid = cmd1_v;
    assign m_axis_sts_tdata   = sts_d;
    assign m_axis_sts_tvalid  = sts_v;
    assign m_axis_sts_tlast   = sts_v;
    assign m_axis_sts_tkeep   = {(STS_W/8){sts_v}};
    assign outstanding        = cnt;
    assign idle               = (cnt == '0) && !cmd0_v && !cmd1_v;

endmodule

// File: tb/tb_dma_cmd_dispatcher.sv
// Randomized and directed bench for dma_cmd_dispatcher against a queue-based reference model.
module tb_dma_cmd_dispatcher;
    import dma_dispatch_pkg::*;

    localparam int CMD_W = 104;
    localparam int STS_W = 32;
    localparam int MAXO  = 16;
    localparam int CNT_W = 5;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic [CMD_W-1:0]   s_axis_cmd_tdata = '0;
    logic [7:0]         s_axis_cmd_tdest = '0;
    logic               s_axis_cmd_tvalid = 1'b0;
    logic               s_axis_cmd_tready;
    logic [CMD_W-1:0]   m_axis_cmd0_tdata, m_axis_cmd1_tdata;
    logic               m_axis_cmd0_tvalid, m_axis_cmd1_tvalid;
    logic               m_axis_cmd0_tready = 1'b0, m_axis_cmd1_tready = 1'b0;
    logic [STS_W-1:0]   s_axis_sts0_tdata = '0, s_axis_sts1_tdata = '0;
    logic               s_axis_sts0_tvalid = 1'b0, s_axis_sts1_tvalid = 1'b0;
    logic               s_axis_sts0_tready, s_axis_sts1_tready;
    logic [STS_W-1:0]   m_axis_sts_tdata;
    logic               m_axis_sts_tvalid;
    logic               m_axis_sts_tready = 1'b0;
    logic               m_axis_sts_tlast;
    logic [STS_W/8-1:0] m_axis_sts_tkeep;
    logic [CNT_W-1:0]   outstanding;
    logic               idle;

    always #5 ap_clk = ~ap_clk;

    dma_cmd_dispatcher #(.CMD_W(CMD_W), .STS_W(STS_W), .MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_axis_cmd_tdata(s_axis_cmd_tdata), .s_axis_cmd_tdest(s_axis_cmd_tdest),
        .s_axis_cmd_tvalid(s_axis_cmd_tvalid), .s_axis_cmd_tready(s_axis_cmd_tready),
        .m_axis_cmd0_tdata(m_axis_cmd0_tdata), .m_axis_cmd0_tvalid(m_axis_cmd0_tvalid),
        .m_axis_cmd0_tready(m_axis_cmd0_tready),
        .m_axis_cmd1_tdata(m_axis_cmd1_tdata), .m_axis_cmd1_tvalid(m_axis_cmd1_tvalid),
        .m_axis_cmd1_tready(m_axis_cmd1_tready),
        .s_axis_sts0_tdata(s_axis_sts0_tdata), .s_axis_sts0_tvalid(s_axis_sts0_tvalid),
        .s_axis_sts0_tready(s_axis_sts0_tready),
        .s_axis_sts1_tdata(s_axis_sts1_tdata), .s_axis_sts1_tvalid(s_axis_sts1_tvalid),
        .s_axis_sts1_tready(s_axis_sts1_tready),
        .m_axis_sts_tdata(m_axis_sts_tdata), .m_axis_sts_tvalid(m_axis_sts_tvalid),
        .m_axis_sts_tready(m_axis_sts_tready), .m_axis_sts_tlast(m_axis_sts_tlast),
        .m_axis_sts_tkeep(m_axis_sts_tkeep), .outstanding(outstanding), .idle(idle)
    );

    typedef struct { logic e; logic [STS_W-1:0] v; } iss_t;

    // Reference model: pending source commands, per-engine command queues, issue order, status out.
    logic [CMD_W-1:0] src_d[$];
    logic             src_e[$];
    logic [CMD_W-1:0] exp_cmd0[$], exp_cmd1[$];
    logic [STS_W-1:0] eng0_q[$], eng1_q[$];
    iss_t             issue_q[$];
    logic [STS_W-1:0] out_q[$];
    logic [STS_W-1:0] seen_sts[$];

    // Drive modes: 0 off, 1 always, 2 random.
    int cmd_mode = 0, osts_mode = 0;
    int eng_rdy[2];
    int sts_mode[2];

    int n_chk = 0, n_pass = 0;
    logic last_cmd_hs, last_cmd_rdy, last_sts_hs, last_sts1_rdy;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic pick(input int m);
        return (m == 1) || (m == 2 && $urandom_range(0, 1) == 1);
    endfunction

    function automatic logic [STS_W-1:0] sts_of(input logic [CMD_W-1:0] d);
        return d[STS_W-1:0] ^ {cmd_tag(d), 28'h0};
    endfunction

    function automatic logic [CMD_W-1:0] rand_cmd();
        logic [CMD_W-1:0] c;
        c = '0;
        c[CMD_BTT_MSB:CMD_BTT_LSB]     = 23'($urandom);
        c[CMD_SADDR_MSB:CMD_SADDR_LSB] = {$urandom, $urandom};
        c[CMD_TAG_MSB:CMD_TAG_LSB]     = 4'($urandom);
        return c;
    endfunction

    task automatic add_cmd(input logic e, input logic [CMD_W-1:0] d);
        src_e.push_back(e);
        src_d.push_back(d);
    endtask

    task automatic drive();
        logic [31:0] junk;
        logic        e;
        junk = $urandom;
        e = (src_e.size() != 0) ? src_e[0] : junk[7];
        s_axis_cmd_tvalid  = (src_d.size() != 0) && pick(cmd_mode);
        s_axis_cmd_tdata   = (src_d.size() != 0) ? src_d[0] : '0;
        s_axis_cmd_tdest   = {junk[6:0], e};
        m_axis_cmd0_tready = pick(eng_rdy[0]);
        m_axis_cmd1_tready = pick(eng_rdy[1]);
        s_axis_sts0_tvalid = (eng0_q.size() != 0) && pick(sts_mode[0]);
        s_axis_sts0_tdata  = (eng0_q.size() != 0) ? eng0_q[0] : '0;
        s_axis_sts1_tvalid = (eng1_q.size() != 0) && pick(sts_mode[1]);
        s_axis_sts1_tdata  = (eng1_q.size() != 0) ? eng1_q[0] : '0;
        m_axis_sts_tready  = pick(osts_mode);
    endtask

    // One clock: drive, check readies/valids against the model, apply handshakes, advance.
    task automatic step();
        logic e, exp_rdy, slot, c0, c1, h0, h1, os;
        drive();
        #2;
        e = s_axis_cmd_tdest[0];
        exp_rdy = (issue_q.size() < MAXO) &&
                  (e ? (exp_cmd1.size() == 0 || m_axis_cmd1_tready)
                     : (exp_cmd0.size() == 0 || m_axis_cmd0_tready));
        slot = (issue_q.size() != 0) && (out_q.size() == 0 || m_axis_sts_tready);
        chk("cmd_tready", s_axis_cmd_tready, exp_rdy);
        chk("cmd0_tvalid", m_axis_cmd0_tvalid, exp_cmd0.size() != 0);
        chk("cmd1_tvalid", m_axis_cmd1_tvalid, exp_cmd1.size() != 0);
        chk("sts_tvalid", m_axis_sts_tvalid, out_q.size() != 0);
        chk("sts0_tready", s_axis_sts0_tready, slot && issue_q[0].e == 1'b0);
        chk("sts1_tready", s_axis_sts1_tready, slot && issue_q[0].e == 1'b1);
        chk("idle", idle, issue_q.size() == 0 && exp_cmd0.size() == 0 && exp_cmd1.size() == 0);

        c0 = m_axis_cmd0_tvalid && m_axis_cmd0_tready;
        c1 = m_axis_cmd1_tvalid && m_axis_cmd1_tready;
        h0 = s_axis_sts0_tvalid && s_axis_sts0_tready;
        h1 = s_axis_sts1_tvalid && s_axis_sts1_tready;
        os = m_axis_sts_tvalid && m_axis_sts_tready;
        last_cmd_hs   = s_axis_cmd_tvalid && s_axis_cmd_tready;
        last_cmd_rdy  = s_axis_cmd_tready;
        last_sts_hs   = h0 || h1;
        last_sts1_rdy = s_axis_sts1_tready;

        if (c0 && exp_cmd0.size() != 0) begin
            chk("cmd0_data", m_axis_cmd0_tdata, exp_cmd0[0]);
            eng0_q.push_back(sts_of(exp_cmd0[0]));
            void'(exp_cmd0.pop_front());
        end
        if (c1 && exp_cmd1.size() != 0) begin
            chk("cmd1_data", m_axis_cmd1_tdata, exp_cmd1[0]);
            eng1_q.push_back(sts_of(exp_cmd1[0]));
            void'(exp_cmd1.pop_front());
        end
        if (os && out_q.size() != 0) begin
            chk("sts_data", m_axis_sts_tdata, out_q[0]);
            chk("sts_tlast", m_axis_sts_tlast, 1'b1);
            chk("sts_tkeep", m_axis_sts_tkeep, 4'hF);
            seen_sts.push_back(m_axis_sts_tdata);
            void'(out_q.pop_front());
        end
        if ((h0 || h1) && issue_q.size() != 0) begin
            chk("sts_src_engine", {h1, h0}, issue_q[0].e ? 2'b10 : 2'b01);
            out_q.push_back(issue_q[0].v);
            void'(issue_q.pop_front());
            if (h0) void'(eng0_q.pop_front());
            if (h1) void'(eng1_q.pop_front());
        end
        if (last_cmd_hs && src_d.size() != 0) begin
            issue_q.push_back('{e: src_e[0], v: sts_of(src_d[0])});
            if (src_e[0]) exp_cmd1.push_back(src_d[0]);
            else          exp_cmd0.push_back(src_d[0]);
            void'(src_d.pop_front());
            void'(src_e.pop_front());
        end
        @(posedge ap_clk);
        #1;
        chk("outstanding", outstanding, issue_q.size());
    endtask

    task automatic set_all(input int m);
        cmd_mode = m; osts_mode = m;
        eng_rdy[0] = m; eng_rdy[1] = m; sts_mode[0] = m; sts_mode[1] = m;
    endtask

    task automatic drain();
        int n;
        set_all(1);
        n = 0;
        while ((src_d.size() + issue_q.size() + out_q.size() + exp_cmd0.size() + exp_cmd1.size()) != 0
               && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) chk("drain_timeout", 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        set_all(0);
        drive();
        repeat (2) @(posedge ap_clk);
        #1;
        src_d.delete(); src_e.delete(); exp_cmd0.delete(); exp_cmd1.delete();
        eng0_q.delete(); eng1_q.delete(); issue_q.delete(); out_q.delete();
        chk("rst_cmd_tready", s_axis_cmd_tready, 1'b0);
        chk("rst_sts_treadys", {s_axis_sts0_tready, s_axis_sts1_tready}, 2'b00);
        chk("rst_valids", {m_axis_cmd0_tvalid, m_axis_cmd1_tvalid, m_axis_sts_tvalid}, 3'b000);
        chk("rst_tdata", {m_axis_cmd0_tdata, m_axis_cmd1_tdata, m_axis_sts_tdata}, '0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_idle", idle, 1'b1);
        ap_rst_n = 1'b1;
        #1;
        chk("post_rst_cmd_tready", s_axis_cmd_tready, 1'b1);
    endtask

    initial begin
        do_reset();

        // Alternating routing, engines always ready.
        set_all(0); cmd_mode = 1; eng_rdy[0] = 1; eng_rdy[1] = 1; osts_mode = 1;
        add_cmd(1'b0, 104'hA); add_cmd(1'b1, 104'hB); add_cmd(1'b0, 104'hC);
        for (int i = 0; i < 3; i++) begin
            logic [CMD_W-1:0] d;
            logic             e;
            d = src_d[0];
            e = src_e[0];
            step();
            chk("alt_accept", last_cmd_hs, 1'b1);
            chk("alt_latency_vld", e ? m_axis_cmd1_tvalid : m_axis_cmd0_tvalid, 1'b1);
            chk("alt_latency_dat", e ? m_axis_cmd1_tdata : m_axis_cmd0_tdata, d);
        end
        chk("alt_outstanding", outstanding, 3);
        drain();

        // Reordered status: engine 1 answers first but must wait for engine 0.
        seen_sts.delete();
        set_all(0); cmd_mode = 1; eng_rdy[0] = 1; eng_rdy[1] = 1; osts_mode = 1; sts_mode[1] = 1;
        add_cmd(1'b0, 104'h11); add_cmd(1'b1, 104'h22);
        repeat (6) begin
            step();
            chk("reorder_sts1_held", last_sts1_rdy, 1'b0);
        end
        drain();
        chk("reorder_first", seen_sts[0], 32'h11);
        chk("reorder_second", seen_sts[1], 32'h22);
        chk("reorder_outstanding", outstanding, 0);

        // Outstanding limit.
        set_all(0); cmd_mode = 1; eng_rdy[0] = 1; eng_rdy[1] = 1; osts_mode = 1;
        for (int i = 0; i < 17; i++) add_cmd(1'(i % 2), 104'(32'h100 + i));
        repeat (20) step();
        chk("full_outstanding", outstanding, 16);
        chk("full_cmd_tready", last_cmd_rdy, 1'b0);
        chk("full_17th_pending", src_d.size(), 1);
        sts_mode[0] = 1;
        step();
        sts_mode[0] = 0;
        chk("full_one_return", last_sts_hs, 1'b1);
        chk("full_out_15", outstanding, 15);
        step();
        chk("full_reenabled", last_cmd_rdy, 1'b1);
        chk("full_out_16", outstanding, 16);
        drain();

        // Engine 0 backpressure with two queued commands.
        set_all(0); cmd_mode = 1; eng_rdy[1] = 1; osts_mode = 1;
        add_cmd(1'b0, 104'h201); add_cmd(1'b0, 104'h202);
        step();
        repeat (5) begin
            step();
            chk("bp_second_stalled", last_cmd_rdy, 1'b0);
            chk("bp_hold_vld", m_axis_cmd0_tvalid, 1'b1);
            chk("bp_hold_dat", m_axis_cmd0_tdata, 104'h201);
        end
        drain();

        // Command and status accepted in the same cycle at outstanding 3.
        set_all(0); cmd_mode = 1; eng_rdy[0] = 1; eng_rdy[1] = 1; osts_mode = 1;
        add_cmd(1'b0, 104'h301); add_cmd(1'b1, 104'h302); add_cmd(1'b0, 104'h303);
        repeat (5) step();
        chk("sim_pre_outstanding", outstanding, 3);
        add_cmd(1'b1, 104'h304);
        sts_mode[0] = 1;
        step();
        sts_mode[0] = 0;
        chk("sim_both_hs", {last_cmd_hs, last_sts_hs}, 2'b11);
        chk("sim_outstanding", outstanding, 3);
        chk("sim_out_valids", {m_axis_cmd1_tvalid, m_axis_sts_tvalid}, 2'b11);
        drain();

        // Random traffic, mid-run reset, more random traffic.
        for (int phase = 0; phase < 2; phase++) begin
            set_all(2);
            for (int i = 0; i < 1500; i++) begin
                if (src_d.size() < 4) add_cmd(1'($urandom), rand_cmd());
                step();
            end
            if (phase == 0) do_reset();
        end
        drain();
        chk("final_idle", idle, 1'b1);
        chk("final_outstanding", outstanding, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dma_cmd_dispatcher.md
Name: dma_cmd_dispatcher

Overview:
- Sits between the CCLO command/status streams and the two datamover engines of the external DMA plugin.
- Routes each incoming datamover command to engine 0 or engine 1 according to tdest[0].
- Tracks issue order in an order FIFO, then merges the two engines' status streams back into one stream, strictly in command-issue order.
- Bounds the number of outstanding commands, so status can never be lost or reordered.

Parameters:
CMD_W, 104, datamover command width (BTT, type, DSA, EOF, DRR, SADDR, TAG)
STS_W, 32, status word width (8 for the mm2s instance, 32 for the s2mm instance)
MAX_OUTSTANDING, 16, order-FIFO depth; power of two, 2..64
CNT_W, 5, width of outstanding counter; must equal clog2(MAX_OUTSTANDING)+1

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  synchronous active-low reset
s_axis_cmd_tdata  in  CMD_W  incoming command
s_axis_cmd_tdest  in  8  engine select; bit 0 used, bits 7:1 ignored
s_axis_cmd_tvalid  in  1  command valid
s_axis_cmd_tready  out  1  command accepted
m_axis_cmd0_tdata  out  CMD_W  command to engine 0
m_axis_cmd0_tvalid  out  1  valid to engine 0
m_axis_cmd0_tready  in  1  engine 0 ready
m_axis_cmd1_tdata  out  CMD_W  command to engine 1
m_axis_cmd1_tvalid  out  1  valid to engine 1
m_axis_cmd1_tready  in  1  engine 1 ready
s_axis_sts0_tdata  in  STS_W  status from engine 0
s_axis_sts0_tvalid  in  1  valid
s_axis_sts0_tready  out  1  ready
s_axis_sts1_tdata  in  STS_W  status from engine 1
s_axis_sts1_tvalid  in  1  valid
s_axis_sts1_tready  out  1  ready
m_axis_sts_tdata  out  STS_W  merged in-order status
m_axis_sts_tvalid  out  1  valid
m_axis_sts_tready  in  1  ready
m_axis_sts_tlast  out  1  constant 1 while valid
m_axis_sts_tkeep  out  STS_W/8  all ones while valid
outstanding  out  CNT_W  commands issued whose status has not yet been returned
idle  out  1  outstanding==0 and both cmd output registers empty

Behaviour:
- Reset (ap_rst_n low at a rising edge of ap_clk):
  - All tvalid outputs 0; all tdata outputs 0; outstanding 0; idle 1; all tready outputs 0 during reset.
  - Order FIFO pointers cleared.
  - Reset mid-operation discards in-flight commands and pending status; no recovery.
- Command path:
  - One output register per engine (cmdN_v, cmdN_d).
  - s_axis_cmd_tready = !fifo_full && (!cmdN_v || m_axis_cmdN_tready), where N = s_axis_cmd_tdest[0]. It is combinational on tdest and tvalid-independent.
  - On accept: cmdN_v is set 1 and cmdN_d loaded; engine id N is pushed into the order FIFO in the same cycle; outstanding increments.
  - Latency is 1 cycle from input acceptance to m_axis_cmdN_tvalid.
  - Full throughput: back-to-back accept to the same engine is allowed when the engine is ready.
  - cmdN_v clears on downstream handshake when no new load occurs.
  - tdata is held stable while tvalid is high and ready is low.
- Status path:
  - Order FIFO head selects the engine whose status is expected next.
  - A single output register (sts_v, sts_d) drives m_axis_sts.
  - s_axis_stsH_tready = !fifo_empty && (!sts_v || m_axis_sts_tready), where H = head. The non-head engine's tready is 0.
  - On status accept: sts_d is loaded, sts_v is set, the FIFO is popped, and outstanding decrements.
  - Latency is 1 cycle from status acceptance to m_axis_sts_tvalid.
  - Status arriving on an engine with no outstanding command is stalled indefinitely (tready 0). It is not dropped.
- Counter and FIFO boundaries:
  - Command accept and status accept in the same cycle leave outstanding unchanged; push and pop proceed together.
  - outstanding == MAX_OUTSTANDING forces s_axis_cmd_tready = 0.
  - Pointers wrap modulo MAX_OUTSTANDING, with an extra MSB for full/empty detection. The counter never under/overflows.
  - Simultaneous push into an empty FIFO and status arrival: the pop is not allowed that cycle (head invalid until the next cycle).

Decomposition:
- Package dma_dispatch_pkg: CMD_W/STS_W defaults, engine_id_t (1 bit), datamover command field offsets (BTT 22:0, SADDR 95:32, TAG 99:96).
- Sub-module dma_order_fifo: synchronous 1-bit-wide FIFO, depth MAX_OUTSTANDING, with push/pop/full/empty/head ports.

Test Plan:
- Reset then idle:
  - Stimulus: assert ap_rst_n=0 for 2 cycles, then release.
  - Required response: all tvalid=0, outstanding=0, idle=1, s_axis_cmd_tready=1.
- Alternating routing:
  - Stimulus: commands with tdest 0,1,0 and tdata 0xA,0xB,0xC, engines always ready.
  - Required response: cmd0 sees A then C, cmd1 sees B, each 1 cycle after accept; outstanding=3.
- Reordered status:
  - Stimulus: engine 1 returns 0x22 before engine 0 returns 0x11.
  - Required response: sts1_tready held 0 until 0x11 is emitted; m_axis_sts shows 0x11 then 0x22, tlast=1 on each; outstanding returns to 0.
- Full limit:
  - Stimulus: issue 16 commands with no status returned.
  - Required response: s_axis_cmd_tready=0 on the 17th. One status return re-enables tready the next cycle; outstanding reads 15 then 16.
- Backpressure:
  - Stimulus: m_axis_cmd0_tready=0 for 5 cycles with 2 commands for engine 0 presented.
  - Required response: first command held stable on m_axis_cmd0; second stalls (tready 0); no loss, order preserved.
- Simultaneous events:
  - Stimulus: command accept and status accept in the same cycle with outstanding=3.
  - Required response: outstanding stays 3; both outputs valid next cycle.
